// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start request with
// operands in, busy/done status and registered result out.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_bin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_diff;
  logic             o_bout;
  logic             o_ovf;

  modport master (
    output i_start, i_a, i_b, i_bin,
    input  o_busy, o_done, o_diff, o_bout, o_ovf
  );

  modport slave (
    input  i_start, i_a, i_b, i_bin,
    output o_busy, o_done, o_diff, o_bout, o_ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per clock LSB first through a
// single full-subtractor cell. Result, borrow and signed overflow are
// registered on entry to the one-cycle done state and held until the next.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   d_sr_q, d_sr_d;
  logic               borrow_q, borrow_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  // Full-subtractor cell on the current LSBs.
  logic d_bit;
  logic borrow_nx;
  assign d_bit     = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
  assign borrow_nx = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      d_sr_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      d_sr_q   <= d_sr_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state: load on start, shift WIDTH times, publish results on the last shift.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    d_sr_d   = d_sr_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          a_sr_d   = bus.i_a;
          b_sr_d   = bus.i_b;
          borrow_d = bus.i_bin;
          a_msb_d  = bus.i_a[WIDTH-1];
          b_msb_d  = bus.i_b[WIDTH-1];
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        d_sr_d   = {d_bit, d_sr_q[WIDTH-1:1]};
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // d_bit is the result MSB on this final shift.
          diff_d  = {d_bit, d_sr_q[WIDTH-1:1]};
          bout_d  = borrow_nx;
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.o_busy = (state_q != StIdle);
  assign bus.o_done = (state_q == StDone);
  assign bus.o_diff = diff_q;
  assign bus.o_bout = bout_q;
  assign bus.o_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed table, back-to-back starts,
// mid-operation reset and random operands, results checked from a scoreboard.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];
  exp_t prev;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Independent reference: 9-bit wide subtraction, borrow is the wrap bit.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] full;
    exp_t       e;
    full   = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    e.diff = full[7:0];
    e.bout = full[8];
    e.ovf  = (a[7] != b[7]) && (full[7] != a[7]);
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.o_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected none at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("diff", int'(bus.o_diff), int'(e.diff));
        chk("bout", int'(bus.o_bout), int'(e.bout));
        chk("ovf", int'(bus.o_ovf), int'(e.ovf));
      end
    end
  end

  // Waits for done after the accepting edge; returns negedges counted from the drive point.
  task automatic wait_done(output int n);
    n = 1;
    while (bus.o_done !== 1'b1 && n < 30) begin
      if (n == 4) begin
        chk("busy_mid", int'(bus.o_busy), 1);
        chk("hold_diff", int'(bus.o_diff), int'(prev.diff));
        chk("hold_bout", int'(bus.o_bout), int'(prev.bout));
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Called just after a negedge: drive one operation and wait for its result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input exp_t e);
    int n;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_bin   = bin;
    bus.i_start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_a     = 8'($urandom);
    bus.i_b     = 8'($urandom);
    bus.i_bin   = 1'($urandom);
    wait_done(n);
    chk("latency", n, 9);
    prev = e;
    @(negedge clk);
  endtask

  vec_t tbl[9];

  initial begin
    int n;
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    prev     = '{8'd0, 1'b0, 1'b0};

    tbl[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 1'b0};
    tbl[1] = '{8'd37,  8'd100, 1'b0, 8'd193, 1'b1, 1'b0};
    tbl[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 1'b0};
    tbl[3] = '{8'd128, 8'd1,   1'b0, 8'd127, 1'b0, 1'b1};
    tbl[4] = '{8'd127, 8'd255, 1'b0, 8'd128, 1'b1, 1'b1};
    tbl[5] = '{8'd255, 8'd0,   1'b1, 8'd254, 1'b0, 1'b0};
    tbl[6] = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1, 1'b0};
    tbl[7] = '{8'd128, 8'd128, 1'b1, 8'd255, 1'b1, 1'b0};
    tbl[8] = '{8'd0,   8'd128, 1'b0, 8'd128, 1'b1, 1'b1};

    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_bin   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_done", int'(bus.o_done), 0);
    chk("rst_diff", int'(bus.o_diff), 0);
    chk("rst_bout", int'(bus.o_bout), 0);
    chk("rst_ovf", int'(bus.o_ovf), 0);

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, '{tbl[i].diff, tbl[i].bout, tbl[i].ovf});
    end

    // Start held high: one result every 10 cycles, busy-time starts ignored.
    bus.i_a     = 8'd10;
    bus.i_b     = 8'd3;
    bus.i_bin   = 1'b0;
    bus.i_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = model(bus.i_a, bus.i_b, bus.i_bin);
      exp_q.push_back(e);
      @(negedge clk);
      bus.i_a   = 8'($urandom);
      bus.i_b   = 8'($urandom);
      bus.i_bin = 1'($urandom);
      wait_done(n);
      chk("b2b_latency", n, 9);
      prev = e;
      @(negedge clk);
      chk("b2b_idle_gap", int'(bus.o_busy), 0);
      if (k == 3) bus.i_start = 1'b0;
    end

    // Reset four cycles into an operation: outputs clear at once, no done.
    bus.i_a     = 8'd200;
    bus.i_b     = 8'd55;
    bus.i_bin   = 1'b1;
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(bus.o_busy), 0);
    chk("abort_diff", int'(bus.o_diff), 0);
    chk("abort_bout", int'(bus.o_bout), 0);
    chk("abort_ovf", int'(bus.o_ovf), 0);
    @(negedge clk);
    rst  = 1'b0;
    prev = '{8'd0, 1'b0, 1'b0};
    repeat (12) @(negedge clk);
    chk("abort_no_done_pending", exp_q.size(), 0);
    run_op(8'd100, 8'd37, 1'b0, '{8'd63, 1'b0, 1'b0});

    // Random operands against the reference model.
    for (int r = 0; r < 1000; r++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbin;
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin, model(ra, rb, rbin));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
